// File: rtl/ptp_rx_parser_if.sv
// Payload stream and Wishbone register bus for the PTP RX parser.
// The master drives the stream and Wishbone requests. The slave is the parser.
interface ptp_rx_parser_if;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        s_axis_tuser;
    logic [31:0] wbs_addr_i;
    logic [31:0] wbs_data_i;
    logic [31:0] wbs_data_o;
    logic        wbs_we_i;
    logic        wbs_stb_i;
    logic        wbs_ack_o;

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        output wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
        input  s_axis_tready, wbs_data_o, wbs_ack_o
    );

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser,
        input  wbs_addr_i, wbs_data_i, wbs_we_i, wbs_stb_i,
        output s_axis_tready, wbs_data_o, wbs_ack_o
    );
endinterface

// File: rtl/ptp_rx_parser.sv
// PTP RX parser: latches PTP header fields from a UDP payload stream. PTP_RX_TS_EN adds the rx_ts_i arrival stamp.
// Latency: results update on the tlast edge and msg_irq_o pulses one cycle later. Wishbone ack follows stb by one cycle.
// Backpressure: none. s_axis_tready is held high after reset, and a frame arriving while valid is set is counted as overflow.
module ptp_rx_parser (
    input  logic           clk,
    input  logic           rst_n,
    ptp_rx_parser_if.slave bus,
`ifdef PTP_RX_TS_EN
    input  logic [79:0]    rx_ts_i,
`endif
    output logic           msg_irq_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_CAPT, ST_DROP} state_t;

    typedef struct packed {
        logic [3:0]  msgtype;
        logic [3:0]  version;
        logic [15:0] seq;
        logic [47:0] sec;
        logic [31:0] ns;
    } msg_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hff) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic        tready_q, beat, eof, cap_en;
    logic [5:0]  byte_cnt_q;
    msg_t        shadow_q, shadow_d, result_q;
    logic        valid_q, valid_eff;
    logic [7:0]  runt_cnt_q, err_cnt_q, ovf_cnt_q;
    logic        long_enough, good, runt_evt, err_evt, acc, latch, ovf_evt;
    logic        wb_req, wb_wr, clr_valid, clr_cnt, ack_q;
    logic [3:0]  reg_sel;
    logic [31:0] rd_dat, rd_q;
    logic        unused_bits;

    assign bus.s_axis_tready = tready_q;
    assign beat              = bus.s_axis_tvalid & tready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (beat) begin
            if (bus.s_axis_tlast) begin
                state_d = ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_CAPT;
                    ST_CAPT: if (byte_cnt_q == 6'd63) state_d = ST_DROP;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_comb begin
        eof    = 1'b0;
        cap_en = 1'b0;
        if (beat) begin
            eof    = bus.s_axis_tlast;
            cap_en = (state_q != ST_DROP);
        end
    end

    // byte_cnt_q is the index of the next beat. It returns to 0 on tlast, so IDLE always sees index 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 6'd0;
        end else if (beat) begin
            if (bus.s_axis_tlast)        byte_cnt_q <= 6'd0;
            else if (byte_cnt_q != 6'd63) byte_cnt_q <= byte_cnt_q + 6'd1;
        end
    end

    // Multi-byte fields are shifted in MSB first, which yields big-endian order.
    always_comb begin
        shadow_d = shadow_q;
        if (cap_en) begin
            if (byte_cnt_q == 6'd0) shadow_d.msgtype = bus.s_axis_tdata[3:0];
            if (byte_cnt_q == 6'd1) shadow_d.version = bus.s_axis_tdata[3:0];
            if (byte_cnt_q inside {[6'd30:6'd31]})
                shadow_d.seq = {shadow_q.seq[7:0], bus.s_axis_tdata};
            if (byte_cnt_q inside {[6'd34:6'd39]})
                shadow_d.sec = {shadow_q.sec[39:0], bus.s_axis_tdata};
            if (byte_cnt_q inside {[6'd40:6'd43]})
                shadow_d.ns = {shadow_q.ns[23:0], bus.s_axis_tdata};
        end
    end

    assign long_enough = (byte_cnt_q >= 6'd43);
    assign good        = long_enough & ~bus.s_axis_tuser & (shadow_d.version == 4'd2);
    assign runt_evt    = eof & ~long_enough;
    assign err_evt     = eof & long_enough & ~good;
    assign acc         = eof & good;

    assign wb_req    = bus.wbs_stb_i & ~ack_q;
    assign wb_wr     = wb_req & bus.wbs_we_i;
    assign reg_sel   = bus.wbs_addr_i[5:2];
    assign clr_valid = wb_wr & (reg_sel == 4'd0) & bus.wbs_data_i[0];
    assign clr_cnt   = wb_wr & (reg_sel == 4'd0) & bus.wbs_data_i[1];

    // A clear that coincides with an accept frees the slot for that same frame.
    assign valid_eff = valid_q & ~clr_valid;
    assign latch     = acc & ~valid_eff;
    assign ovf_evt   = acc & valid_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tready_q   <= 1'b0;
            shadow_q   <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            msg_irq_o  <= 1'b0;
            runt_cnt_q <= 8'd0;
            err_cnt_q  <= 8'd0;
            ovf_cnt_q  <= 8'd0;
        end else begin
            tready_q  <= 1'b1;
            shadow_q  <= shadow_d;
            msg_irq_o <= latch;
            if (latch) begin
                result_q <= shadow_d;
                valid_q  <= 1'b1;
            end else if (clr_valid) begin
                valid_q  <= 1'b0;
            end
            if (clr_cnt) begin
                runt_cnt_q <= 8'd0;
                err_cnt_q  <= 8'd0;
                ovf_cnt_q  <= 8'd0;
            end else begin
                if (runt_evt) runt_cnt_q <= sat_inc(runt_cnt_q);
                if (err_evt)  err_cnt_q  <= sat_inc(err_cnt_q);
                if (ovf_evt)  ovf_cnt_q  <= sat_inc(ovf_cnt_q);
            end
        end
    end

`ifdef PTP_RX_TS_EN
    logic [79:0] ts_shadow_q, ts_result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_shadow_q <= '0;
            ts_result_q <= '0;
        end else begin
            if (cap_en && byte_cnt_q == 6'd0) ts_shadow_q <= rx_ts_i;
            if (latch)                        ts_result_q <= ts_shadow_q;
        end
    end
`endif

    always_comb begin
        rd_dat = 32'd0;
        case (reg_sel)
            4'd0: rd_dat = {ovf_cnt_q, err_cnt_q, runt_cnt_q, 7'd0, valid_q};
            4'd1: rd_dat = {24'd0, result_q.version, result_q.msgtype};
            4'd2: rd_dat = {16'd0, result_q.seq};
            4'd3: rd_dat = {16'd0, result_q.sec[47:32]};
            4'd4: rd_dat = result_q.sec[31:0];
            4'd5: rd_dat = result_q.ns;
`ifdef PTP_RX_TS_EN
            4'd6: rd_dat = {16'd0, ts_result_q[79:64]};
            4'd7: rd_dat = ts_result_q[63:32];
            4'd8: rd_dat = ts_result_q[31:0];
`endif
            default: rd_dat = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            rd_q  <= 32'd0;
        end else begin
            ack_q <= wb_req;
            if (wb_req && !bus.wbs_we_i) rd_q <= rd_dat;
        end
    end

    assign bus.wbs_ack_o  = ack_q;
    assign bus.wbs_data_o = rd_q;

    // The address decode ignores these bits, and only bits 0 and 1 of write data are meaningful.
    assign unused_bits = ^{bus.wbs_addr_i[31:6], bus.wbs_addr_i[1:0], bus.wbs_data_i[31:2]};

endmodule

// File: tb/tb_ptp_rx_parser.sv
// Directed and randomized bench for ptp_rx_parser, checked against a frame-level reference model.
module tb_ptp_rx_parser;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ptp_rx_parser_if bus();
    logic msg_irq;
`ifdef PTP_RX_TS_EN
    logic [79:0] rx_ts;
    logic [79:0] frame_ts;
    logic [79:0] m_ts;
`endif

    ptp_rx_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
`ifdef PTP_RX_TS_EN
        .rx_ts_i   (rx_ts),
`endif
        .msg_irq_o (msg_irq)
    );

    int checks = 0;
    int errors = 0;
    int irq_seen = 0;
    int m_irq = 0;

    logic [7:0]  frame_buf [0:127];
    logic        m_valid;
    logic [3:0]  m_msgtype, m_ver;
    logic [15:0] m_seq;
    logic [47:0] m_sec;
    logic [31:0] m_ns;
    logic [7:0]  m_runt, m_err, m_ovf;

    always @(negedge clk) if (msg_irq) irq_seen <= irq_seen + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_msgtype = '0; m_ver = '0; m_seq = '0; m_sec = '0; m_ns = '0;
        m_runt = '0; m_err = '0; m_ovf = '0;
`ifdef PTP_RX_TS_EN
        m_ts = '0;
`endif
    endtask

    task automatic sat8(inout logic [7:0] c);
        if (c < 8'd255) c = c + 8'd1;
    endtask

    // Frame-level rules: runt, then error, then overflow, else latch.
    task automatic model_frame(input int len, input bit tu, input bit clr);
        bit v;
        v = m_valid && !clr;
        if (len < 44) sat8(m_runt);
        else if (tu || frame_buf[1][3:0] != 4'd2) sat8(m_err);
        else if (v) sat8(m_ovf);
        else begin
            m_msgtype = frame_buf[0][3:0];
            m_ver     = frame_buf[1][3:0];
            m_seq     = {frame_buf[30], frame_buf[31]};
            m_sec     = {frame_buf[34], frame_buf[35], frame_buf[36], frame_buf[37], frame_buf[38], frame_buf[39]};
            m_ns      = {frame_buf[40], frame_buf[41], frame_buf[42], frame_buf[43]};
`ifdef PTP_RX_TS_EN
            m_ts      = frame_ts;
`endif
            v = 1'b1;
            m_irq++;
        end
        m_valid = v;
    endtask

    task automatic do_reset();
        bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.s_axis_tuser = 0; bus.s_axis_tdata = 0;
        bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_addr_i = 0; bus.wbs_data_i = 0;
`ifdef PTP_RX_TS_EN
        rx_ts = '0;
`endif
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("rst_rdata", bus.wbs_data_o, 32'd0);
        chk("rst_irq", {31'd0, msg_irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_tready", {31'd0, bus.s_axis_tready}, 32'd1);
        model_reset();
    endtask

    task automatic wb_access(input logic [31:0] a, input bit we, input logic [31:0] wd, output logic [31:0] rd);
        bit got;
        got = 0;
        rd = 32'hdead_beef;
        bus.wbs_addr_i = a; bus.wbs_we_i = we; bus.wbs_data_i = wd; bus.wbs_stb_i = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.wbs_ack_o) begin got = 1; rd = bus.wbs_data_o; end
        end
        bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        chk("wb_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        wb_access(a, 1'b0, 32'd0, d);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(a, 1'b1, d, dummy);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        wb_read(32'h00, d); chk({tag, "_status"}, d, {m_ovf, m_err, m_runt, 7'd0, m_valid});
        wb_read(32'h04, d); chk({tag, "_type"}, d, {24'd0, m_ver, m_msgtype});
        wb_read(32'h08, d); chk({tag, "_seq"}, d, {16'd0, m_seq});
        wb_read(32'h0C, d); chk({tag, "_sechi"}, d, {16'd0, m_sec[47:32]});
        wb_read(32'h10, d); chk({tag, "_seclo"}, d, m_sec[31:0]);
        wb_read(32'h14, d); chk({tag, "_ns"}, d, m_ns);
`ifdef PTP_RX_TS_EN
        wb_read(32'h18, d); chk({tag, "_tssechi"}, d, {16'd0, m_ts[79:64]});
        wb_read(32'h1C, d); chk({tag, "_tsseclo"}, d, m_ts[63:32]);
        wb_read(32'h20, d); chk({tag, "_tsns"}, d, m_ts[31:0]);
`else
        wb_read(32'h20, d); chk({tag, "_ts_absent"}, d, 32'd0);
`endif
        chk({tag, "_irq"}, irq_seen, m_irq);
    endtask

    task automatic fill_random(input int len);
        for (int i = 0; i < len; i++) frame_buf[i] = 8'($urandom);
`ifdef PTP_RX_TS_EN
        frame_ts = {16'($urandom), 32'($urandom), 32'($urandom)};
`endif
    endtask

    task automatic build_msg(input int len, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [15:0] seq, input logic [47:0] sec, input logic [31:0] ns);
        fill_random(len);
        frame_buf[0] = b0;
        frame_buf[1] = b1;
        frame_buf[30] = seq[15:8];
        frame_buf[31] = seq[7:0];
        for (int k = 0; k < 6; k++) frame_buf[34 + k] = sec[8*(5-k) +: 8];
        for (int k = 0; k < 4; k++) frame_buf[40 + k] = ns[8*(3-k) +: 8];
    endtask

    task automatic drive_beats(input int len, input bit tu, input bit clr, input bit gaps, input bit last);
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.s_axis_tvalid = 1'b0;
                @(posedge clk); #1;
            end
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tdata  = frame_buf[i];
            bus.s_axis_tlast  = last && (i == len - 1);
            bus.s_axis_tuser  = (i == len - 1) ? tu : 1'($urandom);
`ifdef PTP_RX_TS_EN
            rx_ts = (i == 0) ? frame_ts : {16'($urandom), 32'($urandom), 32'($urandom)};
`endif
            if (clr && last && i == len - 1) begin
                bus.wbs_addr_i = 32'h0; bus.wbs_data_i = 32'h1; bus.wbs_we_i = 1'b1; bus.wbs_stb_i = 1'b1;
            end
            @(posedge clk); #1;
            bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int len, input bit tu, input bit clr, input bit gaps);
        drive_beats(len, tu, clr, gaps, 1'b1);
        model_frame(len, tu, clr);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        int len;
        bit tu, clr;

        do_reset();
        check_all("reset");

        build_msg(44, 8'h00, 8'h02, 16'h1234, 48'd5, 32'd1000);
        send_frame(44, 1'b0, 1'b0, 1'b0);
        wb_read(32'h00, d); chk("sync_valid", d, 32'h1);
        wb_read(32'h08, d); chk("sync_seq", d, 32'h1234);
        wb_read(32'h10, d); chk("sync_sec", d, 32'd5);
        wb_read(32'h14, d); chk("sync_ns", d, 32'd1000);
        chk("sync_irq", irq_seen, 1);
        check_all("sync");

        build_msg(30, 8'h00, 8'h02, 16'h4444, 48'd9, 32'd9);
        send_frame(30, 1'b0, 1'b0, 1'b0);
        wb_read(32'h00, d); chk("runt_status", d, 32'h0000_0101);
        build_msg(44, 8'h00, 8'h02, 16'h5555, 48'd9, 32'd9);
        send_frame(44, 1'b1, 1'b0, 1'b0);
        wb_read(32'h00, d); chk("err_status", d, 32'h0001_0101);

        build_msg(50, 8'h08, 8'h02, 16'h6666, 48'd7, 32'd7);
        send_frame(50, 1'b0, 1'b0, 1'b0);
        wb_read(32'h00, d); chk("ovf_status", d, 32'h0101_0101);
        wb_read(32'h08, d); chk("ovf_seq_kept", d, 32'h1234);
        check_all("ovf");

        build_msg(44, 8'h09, 8'h02, 16'h0002, 48'd11, 32'd22);
        send_frame(44, 1'b0, 1'b1, 1'b0);
        wb_read(32'h00, d); chk("clr_race_valid", d[0], 32'd1);
        wb_read(32'h08, d); chk("clr_race_seq", d, 32'h0002);
        check_all("clr_race");

        wb_write(32'h00, 32'h2); m_runt = 0; m_err = 0; m_ovf = 0;
        wb_read(32'h00, d); chk("cnt_clear", d, 32'h1);
        wb_write(32'h24, 32'hffff_ffff);
        wb_write(32'h3C, 32'hffff_ffff);
        wb_read(32'h24, d); chk("unmapped_24", d, 32'd0);
        wb_read(32'h3C, d); chk("unmapped_3c", d, 32'd0);
        check_all("unmapped");

        @(posedge clk); #1;
        bus.wbs_addr_i = 32'h0; bus.wbs_we_i = 1'b0; bus.wbs_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("ack_pattern", {31'd0, bus.wbs_ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        bus.wbs_stb_i = 1'b0;
        @(posedge clk); #1;

        wb_write(32'h00, 32'h1); m_valid = 0;
        build_msg(75, 8'h03, 8'h12, 16'hbeef, 48'h0102_0304_0506, 32'h0a0b_0c0d);
        send_frame(75, 1'b0, 1'b0, 1'b0);
        check_all("long");

        build_msg(44, 8'h00, 8'h02, 16'h0099, 48'd1, 32'd1);
        drive_beats(20, 1'b0, 1'b0, 1'b0, 1'b0);
        do_reset();
        check_all("midrst");
        build_msg(44, 8'h01, 8'h02, 16'h0077, 48'd3, 32'd4);
        send_frame(44, 1'b0, 1'b0, 1'b0);
        wb_read(32'h00, d); chk("midrst_status", d, 32'h1);
        wb_read(32'h08, d); chk("midrst_seq", d, 32'h0077);

        wb_write(32'h00, 32'h1); m_valid = 0;
        build_msg(44, 8'h00, 8'h02, 16'h0101, 48'd2, 32'd3);
`ifdef PTP_RX_TS_EN
        frame_ts = 80'h1_0000_0007;
`endif
        send_frame(44, 1'b0, 1'b0, 1'b0);
`ifdef PTP_RX_TS_EN
        wb_read(32'h1C, d); chk("ts_sec", d, 32'd1);
        wb_read(32'h20, d); chk("ts_ns", d, 32'd7);
`else
        wb_read(32'h20, d); chk("ts_absent", d, 32'd0);
`endif

        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(10, 80);
            fill_random(len);
            frame_buf[1] = {frame_buf[1][7:4], ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'd2};
            tu  = ($urandom_range(0, 7) == 0);
            clr = ($urandom_range(0, 3) == 0);
            send_frame(len, tu, clr, 1'b1);
            check_all("rand");
            if ($urandom_range(0, 1) == 1) begin
                wb_write(32'h00, 32'h1); m_valid = 0;
            end
            if ($urandom_range(0, 9) == 0) begin
                wb_write(32'h00, 32'h2); m_runt = 0; m_err = 0; m_ovf = 0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ptp_rx_parser.md
PTP_RX_PARSER -- requirements
Module: ptp_rx_parser

Interface
REQ-001 The block SHALL have no parameters; the register map and field widths SHALL be fixed as stated below.
REQ-002 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-003 clk  in  1  gmii_rx-domain logic clock; all state SHALL change on its rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 s_axis_tdata  in  8  UDP payload byte from the RX UDP stack.
REQ-006 s_axis_tvalid  in  1  byte valid.
REQ-007 s_axis_tready  out  1  constant 1 out of reset (parser never stalls).
REQ-008 s_axis_tlast  in  1  last payload byte.
REQ-009 s_axis_tuser  in  1  frame error, sampled with tlast.
REQ-010 wbs_addr_i  in  32  byte address, bits [5:2] decoded.
REQ-011 wbs_data_i  in  32  write data.
REQ-012 wbs_data_o  out  32  read data.
REQ-013 wbs_we_i  in  1  write enable.
REQ-014 wbs_stb_i  in  1  strobe.
REQ-015 wbs_ack_o  out  1  acknowledge.
REQ-016 rx_ts_i  in  80  {48-bit sec, 32-bit ns} RTC time; present only with PTP_RX_TS_EN.
REQ-017 msg_irq_o  out  1  one-cycle pulse when a message is latched.

Function
REQ-018 A byte counter SHALL count accepted beats (tvalid&tready) from 0 and saturate at 63.
REQ-019 FSM states: IDLE, CAPT, DROP; IDLE->CAPT on the first beat, storing the byte as byte 0.
REQ-020 In CAPT the block SHALL capture messageType=byte0[3:0], versionPTP=byte1[3:0], sequenceId=bytes30-31, originTimestamp sec=bytes34-39 and ns=bytes40-43, all big-endian, into shadow registers.
REQ-021 At tlast in CAPT the frame SHALL be accepted only if byte count >= 44, tuser=0 and versionPTP=2; otherwise it SHALL be discarded.
REQ-022 A discarded runt (<44 bytes) SHALL increment runt_cnt (8 bit, saturating); other discards SHALL increment err_cnt (8 bit, saturating).
REQ-023 On acceptance, if valid=0 the shadow registers SHALL be copied to result registers, valid set to 1, and msg_irq_o pulsed on the following cycle.
REQ-024 On acceptance with valid=1, the frame SHALL be dropped, result registers SHALL remain unchanged, and ovf_cnt (8 bit, saturating) SHALL increment.
REQ-025 tlast on a beat SHALL return the FSM to IDLE in the same cycle; the next beat SHALL start a new frame.
REQ-026 Bytes beyond 44 SHALL be ignored, and counters SHALL not wrap.
REQ-027 Register map (word offsets): 0x00 status {ovf_cnt[31:24], err_cnt[23:16], runt_cnt[15:8], 7'b0, valid}; 0x04 {24'b0, version[7:4], msgtype[3:0]}; 0x08 {16'b0, seqId}; 0x0C {16'b0, sec[47:32]}; 0x10 sec[31:0]; 0x14 ns.
REQ-028 A write of bit0=1 to 0x00 SHALL clear valid, and a write of bit1=1 SHALL clear all three counters.
REQ-029 If a valid-clear write and an acceptance occur in the same cycle, the new frame SHALL be latched and valid SHALL remain 1.
REQ-030 wbs_ack_o SHALL rise one cycle after wbs_stb_i and stay high for exactly one cycle; stb held high SHALL produce an ack every second cycle.
REQ-031 Unmapped addresses SHALL read 0 and SHALL ignore writes.
REQ-032 The DROP state SHALL be entered from CAPT when a beat arrives after byte 63 saturation, and SHALL exit on tlast with the same accept rules applied.

Reset
REQ-033 On rst_n low: FSM=IDLE, all counters, result and shadow registers =0, valid=0, wbs_ack_o=0, wbs_data_o=0, msg_irq_o=0; s_axis_tready SHALL be 1 once reset is released.
REQ-034 Reset asserted mid-frame SHALL discard the frame without incrementing any counter; the next beat after release SHALL be treated as byte 0.

Configuration
REQ-035 With PTP_RX_TS_EN defined, rx_ts_i SHALL be sampled on the byte-0 beat, carried with the frame, and exposed at 0x18 {16'b0, sec[47:32]}, 0x1C sec[31:0] and 0x20 ns.
REQ-036 Without PTP_RX_TS_EN, the rx_ts_i port SHALL not exist and offsets 0x18-0x20 SHALL read 0.

Verification
REQ-037 44-byte Sync (byte0=0x00, byte1=0x02, seqId=0x1234, sec=5, ns=1000) -> valid=1, 0x08=0x1234, 0x10=5, 0x14=1000, one msg_irq_o pulse.
REQ-038 30-byte frame -> runt_cnt=1, valid unchanged; frame with tuser=1 at tlast -> err_cnt=1.
REQ-039 Two valid frames with no clear between them -> second frame dropped, ovf_cnt=1, seqId of the first frame retained.
REQ-040 Clear write to 0x00 coincident with the tlast of a valid frame (seqId=0x0002) -> valid=1, 0x08=0x0002.
REQ-041 rst_n pulsed low at byte 20, then a full valid frame -> only the second frame latched, all counters 0.
REQ-042 With PTP_RX_TS_EN, rx_ts_i=0x1_0000_0007 at byte 0 -> 0x1C=1, 0x20=7; without the macro -> 0x20 reads 0.
